// File: rtl/l1_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-back / write-allocate L1 cache
// controller. One CPU request is in flight at a time. Misses go out to a
// simple memory port: a writeback of a dirty victim comes first, then a fill
// read (loads only). Saturating miss and writeback counters are exported.
//
// Handshakes: a transfer on a valid/ready pair happens on the rising edge
// where both are 1. The sender holds valid and its payload stable until then.
// The receiver may drive ready regardless of valid. Ready without valid has
// no effect. cpu_rsp_valid and mem_rsp_valid are one-cycle pulses with no
// back-pressure.
module l1_cache_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rsp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req_valid,
  input  logic              mem_ready,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cache_miss,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt,
  output logic [2:0]        dbg_state
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL_REQ  = 3'd3,
    S_FILL_WAIT = 3'd4,
    S_RESP      = 3'd5
  } state_t;

  state_t r_state;
  state_t w_next;

  // Line storage: status bits are reset, tag/data arrays are not.
  logic [LINES-1:0] r_valid;
  logic [LINES-1:0] r_dirty;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  // Registered request and response data.
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [15:0]       r_miss_cnt;
  logic [15:0]       r_wb_cnt;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_req_tag;
  logic               w_hit;
  logic               w_victim_dirty;
  logic               w_lookup;
  logic               w_wb_done;
  logic               w_fill_done;
  logic               w_store_hit;
  logic               w_install;
  logic               w_line_we;
  logic [DATA_W-1:0]  w_line_data;

  assign w_index        = r_addr[INDEX_W-1:0];
  assign w_req_tag      = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_req_tag);
  assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_lookup       = (r_state == S_LOOKUP);
  assign w_wb_done      = (r_state == S_WRITEBACK) && mem_ready;
  assign w_fill_done    = (r_state == S_FILL_WAIT) && mem_rsp_valid;

  // A store miss installs directly once the victim is clean (no fill needed);
  // a load miss installs when the fill data returns.
  assign w_store_hit = w_lookup && w_hit && r_write;
  assign w_install   = (w_lookup && !w_hit && !w_victim_dirty && r_write) ||
                       (w_wb_done && r_write) || w_fill_done;
  assign w_line_we   = !rst && (w_store_hit || w_install);
  assign w_line_data = w_fill_done ? mem_rdata : r_wdata;

  assign miss_cnt  = r_miss_cnt;
  assign wb_cnt    = r_wb_cnt;
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and outputs; reset forces the idle output values.
  always_comb begin
    w_next        = r_state;
    cpu_req_ready = 1'b0;
    cpu_rsp_valid = 1'b0;
    cpu_rdata     = '0;
    mem_req_valid = 1'b0;
    mem_write     = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    cache_miss    = 1'b0;
    case (r_state)
      S_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        cache_miss = !w_hit;
        if (w_hit)               w_next = S_RESP;
        else if (w_victim_dirty) w_next = S_WRITEBACK;
        else if (r_write)        w_next = S_RESP;
        else                     w_next = S_FILL_REQ;
      end
      S_WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_write     = 1'b1;
        mem_addr      = {r_tag[w_index], w_index};
        mem_wdata     = r_data[w_index];
        if (mem_ready) w_next = r_write ? S_RESP : S_FILL_REQ;
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_addr;
        if (mem_ready) w_next = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rsp_valid) w_next = S_RESP;
      end
      S_RESP: begin
        cpu_rsp_valid = 1'b1;
        cpu_rdata     = r_rdata;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (rst) begin
      cpu_req_ready = 1'b1;
      cpu_rsp_valid = 1'b0;
      cpu_rdata     = '0;
      mem_req_valid = 1'b0;
      mem_write     = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      cache_miss    = 1'b0;
    end
  end

  // Capture an accepted request and the data to return in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if ((r_state == S_IDLE) && cpu_req_valid) begin
        r_write <= cpu_write;
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (w_lookup && w_hit && !r_write) r_rdata <= r_data[w_index];
      else if (w_line_we)                r_rdata <= w_line_data;
    end
  end

  // Valid/dirty bits: install sets valid, dirty unless it came from a fill;
  // an accepted writeback cleans the victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_line_we) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= !w_fill_done;
    end else if (w_wb_done) begin
      r_dirty[w_index] <= 1'b0;
    end
  end

  // Tag and data arrays.
  always_ff @(posedge clk) begin
    if (w_line_we) begin
      r_tag[w_index]  <= w_req_tag;
      r_data[w_index] <= w_line_data;
    end
  end

  // Saturating miss and writeback counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (w_lookup && !w_hit && (r_miss_cnt != 16'hFFFF)) r_miss_cnt <= r_miss_cnt + 16'd1;
      if (w_wb_done && (r_wb_cnt != 16'hFFFF))            r_wb_cnt   <= r_wb_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: directed vector table, stall / stray-response /
// mid-transaction-reset sequences, then random loads and stores checked
// against a reference cache plus a flat backing-memory model.
module tb_l1_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_write;
  logic [15:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_rsp_valid;
  logic [31:0] cpu_rdata;
  logic        mem_req_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        cache_miss;
  logic [15:0] miss_cnt;
  logic [15:0] wb_cnt;
  logic [2:0]  dbg_state;

  l1_cache_ctrl #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
    .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rdata(cpu_rdata),
    .mem_req_valid(mem_req_valid), .mem_ready(mem_ready),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .cache_miss(cache_miss), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
  } txn_t;

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_miss;
    int          exp_nmem;
    int          exp_miss_cnt;
    int          exp_wb_cnt;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: direct-mapped cache contents and backing memory.
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [11:0] m_tag   [16];
  logic [31:0] m_data  [16];
  int          ref_miss;
  int          ref_wb;
  logic [31:0] ref_back [logic [15:0]];
  logic [31:0] exp_q [$];

  // Memory responder state (written only by the responder process).
  logic [31:0] mem_model [logic [15:0]];
  txn_t        mem_log [$];
  int          stall_seen = 0;
  int          stall_bad  = 0;

  // Responder controls (written only by the main process).
  int          stall_gen = 0;
  int          stall_cfg = 0;
  logic [15:0] stall_addr = 16'h0;
  int          stray_gen = 0;
  int          stray_cfg = 0;
  int          fill_delay_cfg = -1;

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return {a, ~a} ^ 32'h3C3C_A5A5;
  endfunction

  function automatic logic [31:0] back_read(input logic [15:0] a);
    if (ref_back.exists(a)) return ref_back[a];
    return init_val(a);
  endfunction

  function automatic logic [31:0] mem_read(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return init_val(a);
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    ref_miss = 0;
    ref_wb   = 0;
    exp_q.delete();
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_ready"},     cpu_req_ready, 1);
    chk({tag, "_rsp_valid"}, cpu_rsp_valid, 0);
    chk({tag, "_mem_valid"}, mem_req_valid, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_miss"},      cache_miss, 0);
    chk({tag, "_rdata"},     cpu_rdata, 0);
    chk({tag, "_mem_addr"},  mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // ---------------- memory responder ----------------
  initial begin : mem_responder
    int          last_sg, last_tg, stall_left, stray_left, fill_wait;
    bit          fill_pend, stalling;
    logic [15:0] fill_addr;
    txn_t        t;
    last_sg = 0; last_tg = 0; stall_left = 0; stray_left = 0; fill_wait = 0;
    fill_pend = 1'b0; stalling = 1'b0; fill_addr = 16'h0;
    mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    mem_model[16'h0010] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      if (stalling) begin
        stall_seen++;
        if (!(mem_req_valid === 1'b1 && mem_write === 1'b0 && mem_addr === stall_addr)) stall_bad++;
      end
      if (mem_req_valid && mem_ready) begin
        t.w = mem_write;
        t.a = mem_addr;
        if (mem_write) begin
          t.d = mem_wdata;
          mem_model[mem_addr] = mem_wdata;
        end else begin
          t.d = 32'h0;
          fill_pend = 1'b1;
          fill_addr = mem_addr;
          fill_wait = (fill_delay_cfg >= 0) ? fill_delay_cfg : int'($urandom_range(0, 3));
        end
        mem_log.push_back(t);
      end
      @(posedge clk);
      #1;
      mem_rsp_valid = 1'b0;
      stalling = 1'b0;
      if (stray_gen != last_tg) begin last_tg = stray_gen; stray_left = stray_cfg; end
      if (stall_gen != last_sg) begin last_sg = stall_gen; stall_left = stall_cfg; end
      if (stray_left > 0) begin
        mem_rsp_valid = 1'b1;
        mem_rdata = $urandom;
        stray_left--;
      end else if (fill_pend) begin
        if (fill_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rdata = mem_read(fill_addr);
          fill_pend = 1'b0;
        end else begin
          fill_wait--;
        end
      end
      if (mem_req_valid) begin
        if (stall_left > 0) begin
          mem_ready = 1'b0;
          stall_left--;
          stalling = 1'b1;
        end else begin
          mem_ready = ($urandom_range(0, 3) != 0);
        end
      end else begin
        mem_ready = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // ---------------- driver + per-transaction scoreboard ----------------
  task automatic do_req(input logic w, input logic [15:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output int nmiss, output int nmem);
    logic [3:0]  idx;
    logic [11:0] tg;
    bit          hit, got;
    txn_t        t;
    txn_t        exp_t [$];
    int          base, n, ready_bad, lim;
    logic [31:0] exp_rd;

    // Predict from the reference model.
    idx = a[3:0];
    tg  = a[15:4];
    hit = m_valid[idx] && (m_tag[idx] == tg);
    if (hit) begin
      if (w) begin
        m_data[idx]  = d;
        m_dirty[idx] = 1'b1;
      end
    end else begin
      ref_miss = sat16(ref_miss + 1);
      if (m_valid[idx] && m_dirty[idx]) begin
        t.w = 1'b1; t.a = {m_tag[idx], idx}; t.d = m_data[idx];
        exp_t.push_back(t);
        ref_back[{m_tag[idx], idx}] = m_data[idx];
        ref_wb = sat16(ref_wb + 1);
      end
      if (!w) begin
        t.w = 1'b0; t.a = a; t.d = 32'h0;
        exp_t.push_back(t);
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_dirty[idx] = w;
      m_data[idx]  = w ? d : back_read(a);
    end
    exp_q.push_back(m_data[idx]);

    // Drive the request and wait for acceptance.
    base = mem_log.size();
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1;
    cpu_write = w;
    cpu_addr  = a;
    cpu_wdata = d;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("req_accepted", cpu_req_ready, 1);
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_write = 1'($urandom);
    cpu_addr  = 16'($urandom);
    cpu_wdata = $urandom;

    // Collect the response.
    lat = 0; nmiss = 0; got = 1'b0; ready_bad = 0; rd = 32'h0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cache_miss) nmiss++;
      if (cpu_req_ready) ready_bad++;
      if (cpu_rsp_valid) begin
        got = 1'b1;
        rd  = cpu_rdata;
      end
    end
    chk("rsp_seen", got, 1);
    exp_rd = exp_q.pop_front();
    chk($sformatf("rdata@%04h", a), rd, exp_rd);
    chk("miss_pulse", nmiss, hit ? 0 : 1);
    chk("ready_low_busy", ready_bad, 0);
    chk("miss_cnt", miss_cnt, ref_miss);
    chk("wb_cnt", wb_cnt, ref_wb);
    nmem = mem_log.size() - base;
    chk("mem_txn_cnt", nmem, exp_t.size());
    lim = (nmem < exp_t.size()) ? nmem : exp_t.size();
    for (int i = 0; i < lim; i++) chk($sformatf("mem_txn%0d", i), 64'(mem_log[base + i]), 64'(exp_t[i]));
    @(negedge clk);
    chk("rsp_one_cycle", cpu_rsp_valid, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    vec_t        tbl [6];
    logic [31:0] rd;
    int          lat, nmiss, nmem, n, base, s0, b0, n_rsp, n_mreq, bad;
    logic [15:0] ra;

    cpu_req_valid = 1'b0; cpu_write = 1'b0; cpu_addr = 16'h0; cpu_wdata = 32'h0;
    rst = 1'b1;
    ref_back[16'h0010] = 32'hDEADBEEF;
    model_reset();

    tbl[0] = '{1'b0, 16'h0010, 32'h0,         32'hDEADBEEF,         1, 1, 1, 0};
    tbl[1] = '{1'b0, 16'h0010, 32'h0,         32'hDEADBEEF,         0, 0, 1, 0};
    tbl[2] = '{1'b1, 16'h0010, 32'h11111111,  32'h11111111,         0, 0, 1, 0};
    tbl[3] = '{1'b0, 16'h0020, 32'h0,         init_val(16'h0020),   1, 2, 2, 1};
    tbl[4] = '{1'b1, 16'h0033, 32'hA5A5A5A5,  32'hA5A5A5A5,         1, 0, 3, 1};
    tbl[5] = '{1'b0, 16'h0033, 32'h0,         32'hA5A5A5A5,         0, 0, 3, 1};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst_outputs("rst");
    chk("rst_miss_cnt", miss_cnt, 0);
    chk("rst_wb_cnt", wb_cnt, 0);
    chk("rst_state_idle", dbg_state, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      do_req(tbl[i].w, tbl[i].a, tbl[i].d, rd, lat, nmiss, nmem);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_miss", i), nmiss, tbl[i].exp_miss);
      chk($sformatf("vec%0d_nmem", i), nmem, tbl[i].exp_nmem);
      chk($sformatf("vec%0d_miss_cnt", i), miss_cnt, tbl[i].exp_miss_cnt);
      chk($sformatf("vec%0d_wb_cnt", i), wb_cnt, tbl[i].exp_wb_cnt);
      if (tbl[i].exp_nmem == 0) chk($sformatf("vec%0d_latency", i), lat, 2);
    end
    chk("wb_data_0010", mem_read(16'h0010), 32'h11111111);

    // Fill request held off by memory for 5 cycles.
    stall_addr = 16'h0045;
    stall_cfg  = 5;
    stall_gen++;
    s0 = stall_seen;
    b0 = stall_bad;
    do_req(1'b0, 16'h0045, 32'h0, rd, lat, nmiss, nmem);
    chk("stall_cycles", stall_seen - s0, 5);
    chk("stall_stable", stall_bad - b0, 0);
    chk("stall_rdata", rd, init_val(16'h0045));

    // Stray memory responses while idle are ignored.
    stray_cfg = 4;
    stray_gen++;
    n_rsp = 0; n_mreq = 0;
    repeat (8) begin
      @(negedge clk);
      if (cpu_rsp_valid) n_rsp++;
      if (mem_req_valid) n_mreq++;
    end
    chk("stray_no_rsp", n_rsp, 0);
    chk("stray_no_mreq", n_mreq, 0);
    do_req(1'b0, 16'h0045, 32'h0, rd, lat, nmiss, nmem);
    chk("stray_reload_hit", nmiss, 0);
    chk("stray_reload_rdata", rd, init_val(16'h0045));

    // Reset while waiting for fill data.
    fill_delay_cfg = 12;
    base = mem_log.size();
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0077; cpu_wdata = 32'h0;
    n = 0;
    @(negedge clk);
    while (!cpu_req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    n = 0;
    while (mem_log.size() == base && n < 100) begin @(negedge clk); n++; end
    chk("midrst_fill_issued", mem_log.size() - base, 1);
    @(negedge clk);
    chk("midrst_wait_no_mreq", mem_req_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_rst_outputs("midrst");
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_miss_cnt", miss_cnt, 0);
    chk("midrst_wb_cnt", wb_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    n_rsp = 0; n_mreq = 0;
    repeat (20) begin
      @(negedge clk);
      if (cpu_rsp_valid) n_rsp++;
      if (mem_req_valid) n_mreq++;
    end
    chk("midrst_no_rsp", n_rsp, 0);
    chk("midrst_no_mreq", n_mreq, 0);
    fill_delay_cfg = -1;
    do_req(1'b0, 16'h0010, 32'h0, rd, lat, nmiss, nmem);
    chk("postrst_miss", nmiss, 1);
    chk("postrst_rdata", rd, 32'h11111111);

    // Random loads and stores over a small address window.
    for (int i = 0; i < 300; i++) begin
      ra = {12'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      do_req(($urandom_range(0, 1) == 1), ra, $urandom, rd, lat, nmiss, nmem);
    end

    // Backing memory must hold exactly what the model wrote back.
    bad = 0;
    foreach (ref_back[k]) begin
      if (!mem_model.exists(k) || mem_model[k] !== ref_back[k]) bad++;
    end
    chk("backing_mem_content", bad, 0);
    chk("backing_mem_size", mem_model.num(), ref_back.num());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
